// File: rtl/fdd_sector_server.sv
// Drive-side sector server for a WD2793 FDC: maps (track,side,sector) to an SD LBA and streams 512-byte sectors.
// Define FDD_SERVER_WRITE_EN to build the write path; otherwise every write request is rejected as write-protected.
module fdd_sector_server #(
   parameter int SPT    = 9,
   parameter int SIDES  = 2,
   parameter int TRACKS = 80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        img_present,
   input  logic        img_readonly,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [6:0]  req_track,
   input  logic        req_side,
   input  logic [7:0]  req_sector,
   input  logic        req_abort,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic        done,
   output logic        err_rnf,
   output logic        err_wp,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic [8:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   output logic [7:0]  sd_buff_din,
   input  logic        sd_buff_wr
);
   typedef enum logic [2:0] {IDLE, SD_READ, STREAM, COLLECT, SD_WRITE, FINISH} state_t;

   state_t      state_q, state_d;
   logic [8:0]  idx_q, idx_d;
   logic [31:0] lba_q, lba_d;
   logic        sd_rd_q, sd_rd_d;
   logic        issued_q, issued_d;
   logic        seen_q, seen_d;
   logic        err_rnf_q, err_rnf_d;
   logic        err_wp_q, err_wp_d;
   logic        abort_q, abort_d;

   logic [7:0]  mem [0:511];
   logic [7:0]  mem_rd_q;
   logic [8:0]  rd_addr;
   logic        mem_we;
   logic [8:0]  mem_waddr;
   logic [7:0]  mem_wdata;

   logic [31:0] req_lba;
   logic        req_bad;

   assign req_lba = ({25'd0, req_track} * 32'(SIDES) + {31'd0, req_side}) * 32'(SPT)
                    + {24'd0, req_sector} - 32'd1;
   assign req_bad = !img_present || (req_sector == 8'd0) || ({24'd0, req_sector} > 32'(SPT))
                    || ({25'd0, req_track} >= 32'(TRACKS)) || ({31'd0, req_side} >= 32'(SIDES));

`ifdef FDD_SERVER_WRITE_EN
   logic sd_wr_q, sd_wr_d;
`else
   logic unused_write_inputs;
   assign unused_write_inputs = ^{img_readonly, wr_data, wr_valid};
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lba_d     = lba_q;
      sd_rd_d   = sd_rd_q;
      issued_d  = issued_q;
      seen_d    = seen_q;
      err_rnf_d = err_rnf_q;
      err_wp_d  = err_wp_q;
      abort_d   = abort_q;
      mem_we    = 1'b0;
      mem_waddr = sd_buff_addr;
      mem_wdata = sd_buff_dout;
`ifdef FDD_SERVER_WRITE_EN
      sd_wr_d   = sd_wr_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               err_rnf_d = 1'b0;
               err_wp_d  = 1'b0;
               abort_d   = 1'b0;
               issued_d  = 1'b0;
               seen_d    = 1'b0;
               idx_d     = 9'd0;
               if (req_bad) begin
                  err_rnf_d = 1'b1;
                  state_d   = FINISH;
`ifdef FDD_SERVER_WRITE_EN
               end else if (req_write && img_readonly) begin
                  err_wp_d = 1'b1;
                  state_d  = FINISH;
               end else begin
                  lba_d   = req_lba;
                  state_d = req_write ? COLLECT : SD_READ;
               end
`else
               end else if (req_write) begin
                  err_wp_d = 1'b1;
                  state_d  = FINISH;
               end else begin
                  lba_d   = req_lba;
                  state_d = SD_READ;
               end
`endif
            end
         end
         SD_READ: begin
            mem_we = sd_buff_wr;
            if (req_abort) abort_d = 1'b1;
            // Stale sd_ack (e.g. after reset mid-transfer) must drain before a new command.
            if (!issued_q) begin
               if (!sd_ack) begin
                  sd_rd_d  = 1'b1;
                  issued_d = 1'b1;
               end
            end else if (!seen_q) begin
               if (sd_ack) begin
                  sd_rd_d = 1'b0;
                  seen_d  = 1'b1;
               end
            end else if (!sd_ack) begin
               idx_d   = 9'd0;
               state_d = (abort_q || req_abort) ? FINISH : STREAM;
            end
         end
         STREAM: begin
            if (req_abort) begin
               state_d = FINISH;
            end else if (rd_ready) begin
               if (idx_q == 9'd511) state_d = FINISH;
               else                 idx_d   = idx_q + 9'd1;
            end
         end
`ifdef FDD_SERVER_WRITE_EN
         COLLECT: begin
            if (req_abort) begin
               state_d = FINISH;
            end else if (wr_valid) begin
               mem_we    = 1'b1;
               mem_waddr = idx_q;
               mem_wdata = wr_data;
               if (idx_q == 9'd511) state_d = SD_WRITE;
               else                 idx_d   = idx_q + 9'd1;
            end
         end
         SD_WRITE: begin
            if (!issued_q) begin
               if (!sd_ack) begin
                  sd_wr_d  = 1'b1;
                  issued_d = 1'b1;
               end
            end else if (!seen_q) begin
               if (sd_ack) begin
                  sd_wr_d = 1'b0;
                  seen_d  = 1'b1;
               end
            end else if (!sd_ack) begin
               state_d = FINISH;
            end
         end
`endif
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= 9'd0;
         lba_q     <= 32'd0;
         sd_rd_q   <= 1'b0;
         issued_q  <= 1'b0;
         seen_q    <= 1'b0;
         err_rnf_q <= 1'b0;
         err_wp_q  <= 1'b0;
         abort_q   <= 1'b0;
`ifdef FDD_SERVER_WRITE_EN
         sd_wr_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lba_q     <= lba_d;
         sd_rd_q   <= sd_rd_d;
         issued_q  <= issued_d;
         seen_q    <= seen_d;
         err_rnf_q <= err_rnf_d;
         err_wp_q  <= err_wp_d;
         abort_q   <= abort_d;
`ifdef FDD_SERVER_WRITE_EN
         sd_wr_q   <= sd_wr_d;
`endif
      end
   end

   // Read port looks one step ahead (idx_d) so rd_data is buffer[idx_q] whenever rd_valid is high.
`ifdef FDD_SERVER_WRITE_EN
   assign rd_addr = (state_q == SD_WRITE) ? sd_buff_addr : idx_d;
`else
   assign rd_addr = idx_d;
`endif

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      mem_rd_q <= mem[rd_addr];
   end

   assign req_ready = (state_q == IDLE);
   assign rd_valid  = (state_q == STREAM);
   assign rd_data   = mem_rd_q;
   assign done      = (state_q == FINISH);
   assign err_rnf   = err_rnf_q;
   assign err_wp    = err_wp_q;
   assign sd_lba    = lba_q;
   assign sd_rd     = sd_rd_q;
`ifdef FDD_SERVER_WRITE_EN
   assign wr_ready    = (state_q == COLLECT);
   assign sd_wr       = sd_wr_q;
   assign sd_buff_din = mem_rd_q;
`else
   assign wr_ready    = 1'b0;
   assign sd_wr       = 1'b0;
   assign sd_buff_din = 8'hFF;
`endif
endmodule

// File: tb/tb_fdd_sector_server.sv
// Directed bench for fdd_sector_server: reads, record-not-found, write path (or its absence), abort, reset mid-transfer.
module tb_fdd_sector_server;
   logic        clk = 1'b0;
   logic        reset, img_present, img_readonly, req_valid, req_write, req_side, req_abort;
   logic [6:0]  req_track;
   logic [7:0]  req_sector, wr_data, sd_buff_dout;
   logic        rd_ready, wr_valid, sd_ack, sd_buff_wr;
   logic [8:0]  sd_buff_addr;
   logic        req_ready, rd_valid, wr_ready, done, err_rnf, err_wp, sd_rd, sd_wr;
   logic [7:0]  rd_data, sd_buff_din;
   logic [31:0] sd_lba;
   int checks = 0;
   int failures = 0;

   fdd_sector_server dut (
      .clk(clk), .reset(reset), .img_present(img_present), .img_readonly(img_readonly),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_track(req_track),
      .req_side(req_side), .req_sector(req_sector), .req_abort(req_abort),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .done(done), .err_rnf(err_rnf), .err_wp(err_wp),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
      .sd_buff_wr(sd_buff_wr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pat(input logic [31:0] lba, input int i);
      return 8'(i) ^ lba[7:0] ^ ((i >= 256) ? 8'hA5 : 8'h00);
   endfunction

   function automatic logic [7:0] wpat(input int i);
      return 8'(i * 3) ^ 8'h5C;
   endfunction

   task automatic issue(input logic wr, input logic [6:0] trk, input logic sd, input logic [7:0] sec);
      req_write = wr; req_track = trk; req_side = sd; req_sector = sec; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic sd_fill(input logic [31:0] lba);
      sd_ack = 1'b1;
      step();
      for (int i = 0; i < 512; i++) begin
         sd_buff_addr = 9'(i); sd_buff_dout = pat(lba, i); sd_buff_wr = 1'b1;
         step();
      end
      sd_buff_wr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready actual=%b required=1", req_ready); end
      checks++;
      if ({rd_valid, wr_ready, done, err_rnf, err_wp, sd_rd, sd_wr} !== 7'd0) begin
         failures++; $display("FAIL reset_outputs actual=%b required=0000000", {rd_valid, wr_ready, done, err_rnf, err_wp, sd_rd, sd_wr});
      end
      checks++;
      if (sd_lba !== 32'd0) begin failures++; $display("FAIL reset_sd_lba actual=%0d required=0", sd_lba); end
      $display("reset: req_ready=%b sd_lba=%0d", req_ready, sd_lba);
   endtask

   task automatic test_read(input logic [6:0] trk, input logic sd, input logic [7:0] sec,
                            input logic [31:0] exp_lba, input bit rand_ready);
      int k, n, cyc, bad, first_bad;
      logic [7:0] held;
      bit stall;
      issue(1'b0, trk, sd, sec);
      checks++;
      if (req_ready !== 1'b0) begin failures++; $display("FAIL read_busy_ready actual=%b required=0", req_ready); end
      k = 0;
      while (sd_rd !== 1'b1 && k < 20) begin step(); k++; end
      checks++;
      if (sd_rd !== 1'b1) begin failures++; $display("FAIL read_sd_rd actual=%b required=1", sd_rd); end
      checks++;
      if (sd_lba !== exp_lba) begin failures++; $display("FAIL read_sd_lba actual=%0d required=%0d", sd_lba, exp_lba); end
      sd_fill(exp_lba);
      checks++;
      if (sd_rd !== 1'b0) begin failures++; $display("FAIL read_sd_rd_clear actual=%b required=0", sd_rd); end
      sd_ack = 1'b0;
      step();
      n = 0; cyc = 0; bad = 0; first_bad = -1; stall = 1'b0; held = 8'h00;
      while (n < 512 && cyc < 5000) begin
         if (rd_valid === 1'b1) begin
            if (rd_data !== pat(exp_lba, n) || (stall && rd_data !== held)) begin
               bad++;
               if (first_bad < 0) first_bad = n;
            end
            rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = !rd_ready;
            held = rd_data;
            if (rd_ready) n++;
         end else begin
            rd_ready = 1'b0;
         end
         step();
         cyc++;
      end
      rd_ready = 1'b0;
      checks++;
      if (n != 512 || bad != 0) begin
         failures++; $display("FAIL read_data bytes=%0d required=512 bad=%0d first_bad=%0d", n, bad, first_bad);
      end
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL read_done actual=%b required=1", done); end
      checks++;
      if ({err_rnf, err_wp} !== 2'b00) begin failures++; $display("FAIL read_err actual=%b required=00", {err_rnf, err_wp}); end
      step();
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL read_idle ready=%b done=%b required ready=1 done=0", req_ready, done);
      end
      $display("read T%0d S%0d sec%0d lba=%0d bytes=%0d", trk, sd, sec, sd_lba, n);
   endtask

   task automatic test_rnf();
      logic [6:0] trk [4] = '{7'd0, 7'd0, 7'd80, 7'd3};
      logic [7:0] sec [4] = '{8'd0, 8'd10, 8'd1, 8'd2};
      logic       pres[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int v = 0; v < 4; v++) begin
         int k;
         bit rd_seen;
         img_present = pres[v];
         issue(1'b0, trk[v], 1'b0, sec[v]);
         rd_seen = (sd_rd === 1'b1);
         k = 1;
         while (done !== 1'b1 && k < 2) begin step(); k++; rd_seen |= (sd_rd === 1'b1); end
         checks++;
         if (done !== 1'b1) begin failures++; $display("FAIL rnf_done vec=%0d actual=%b required=1", v, done); end
         checks++;
         if ({err_rnf, err_wp} !== 2'b10) begin failures++; $display("FAIL rnf_err vec=%0d actual=%b required=10", v, {err_rnf, err_wp}); end
         step();
         rd_seen |= (sd_rd === 1'b1);
         checks++;
         if (rd_seen) begin failures++; $display("FAIL rnf_sd_rd vec=%0d actual=1 required=0", v); end
         $display("rnf vec=%0d T%0d sec%0d present=%b err_rnf=%b", v, trk[v], sec[v], pres[v], err_rnf);
      end
      img_present = 1'b1;
   endtask

`ifdef FDD_SERVER_WRITE_EN
   task automatic test_write();
      int k, n, cyc, bad;
      img_readonly = 1'b0;
      issue(1'b1, 7'd1, 1'b0, 8'd3);
      n = 0; cyc = 0;
      while (n < 512 && cyc < 2000) begin
         if (wr_ready === 1'b1) begin wr_valid = 1'b1; wr_data = wpat(n); n++; end
         else wr_valid = 1'b0;
         step();
         cyc++;
      end
      wr_valid = 1'b0;
      k = 0;
      while (sd_wr !== 1'b1 && k < 20) begin step(); k++; end
      checks++;
      if (sd_wr !== 1'b1) begin failures++; $display("FAIL write_sd_wr actual=%b required=1", sd_wr); end
      checks++;
      if (sd_lba !== 32'd20) begin failures++; $display("FAIL write_sd_lba actual=%0d required=20", sd_lba); end
      sd_ack = 1'b1;
      step();
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         sd_buff_addr = 9'(i);
         step();
         if (sd_buff_din !== wpat(i)) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL write_buff_din bad=%0d required=0", bad); end
      sd_ack = 1'b0;
      step();
      checks++;
      if (done !== 1'b1 || {err_rnf, err_wp} !== 2'b00) begin
         failures++; $display("FAIL write_done done=%b err=%b required done=1 err=00", done, {err_rnf, err_wp});
      end
      step();
      $display("write T1 S0 sec3 lba=%0d bytes=%0d", sd_lba, n);
      img_readonly = 1'b1;
      issue(1'b1, 7'd1, 1'b0, 8'd3);
      k = 1;
      while (done !== 1'b1 && k < 2) begin step(); k++; end
      checks++;
      if (done !== 1'b1 || {err_rnf, err_wp} !== 2'b01 || sd_wr !== 1'b0) begin
         failures++; $display("FAIL write_ro done=%b err=%b sd_wr=%b required done=1 err=01 sd_wr=0", done, {err_rnf, err_wp}, sd_wr);
      end
      step();
      img_readonly = 1'b0;
      $display("write readonly err_wp=%b", err_wp);
   endtask
`else
   task automatic test_write_disabled();
      int k;
      bit wr_seen;
      img_readonly = 1'b0;
      wr_valid = 1'b1;
      issue(1'b1, 7'd1, 1'b0, 8'd3);
      wr_seen = (wr_ready === 1'b1) || (sd_wr === 1'b1);
      k = 1;
      while (done !== 1'b1 && k < 2) begin step(); k++; wr_seen |= (wr_ready === 1'b1) || (sd_wr === 1'b1); end
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL wrdis_done actual=%b required=1", done); end
      checks++;
      if ({err_rnf, err_wp} !== 2'b01) begin failures++; $display("FAIL wrdis_err actual=%b required=01", {err_rnf, err_wp}); end
      for (int i = 0; i < 8; i++) begin step(); wr_seen |= (wr_ready === 1'b1) || (sd_wr === 1'b1); end
      wr_valid = 1'b0;
      checks++;
      if (wr_seen) begin failures++; $display("FAIL wrdis_wr_ready actual=1 required=0"); end
      $display("write disabled err_wp=%b", err_wp);
   endtask
`endif

   task automatic test_abort();
      int k, n;
      issue(1'b0, 7'd2, 1'b1, 8'd4);
      k = 0;
      while (sd_rd !== 1'b1 && k < 20) begin step(); k++; end
      checks++;
      if (sd_lba !== 32'd48) begin failures++; $display("FAIL abort_sd_lba actual=%0d required=48", sd_lba); end
      sd_fill(32'd48);
      sd_ack = 1'b0;
      step();
      n = 0; k = 0;
      while (n < 100 && k < 400) begin
         rd_ready = (rd_valid === 1'b1);
         if (rd_ready) n++;
         step();
         k++;
      end
      rd_ready = 1'b0;
      req_abort = 1'b1;
      step();
      req_abort = 1'b0;
      checks++;
      if (done !== 1'b1 || {err_rnf, err_wp} !== 2'b00 || sd_wr !== 1'b0) begin
         failures++; $display("FAIL abort_done done=%b err=%b sd_wr=%b required done=1 err=00 sd_wr=0", done, {err_rnf, err_wp}, sd_wr);
      end
      step();
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready actual=%b required=1", req_ready); end
      $display("abort after %0d bytes done", n);
   endtask

   task automatic test_reset_with_ack();
      int k;
      bit early;
      issue(1'b0, 7'd0, 1'b0, 8'd1);
      k = 0;
      while (sd_rd !== 1'b1 && k < 20) begin step(); k++; end
      sd_ack = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      issue(1'b0, 7'd0, 1'b0, 8'd2);
      early = 1'b0;
      for (int i = 0; i < 6; i++) begin early |= (sd_rd === 1'b1); step(); end
      early |= (sd_rd === 1'b1);
      checks++;
      if (early) begin failures++; $display("FAIL rstack_early_sd_rd actual=1 required=0"); end
      sd_ack = 1'b0;
      k = 0;
      while (sd_rd !== 1'b1 && k < 10) begin step(); k++; end
      checks++;
      if (sd_rd !== 1'b1) begin failures++; $display("FAIL rstack_sd_rd actual=%b required=1", sd_rd); end
      sd_ack = 1'b1;
      req_abort = 1'b1;
      step();
      req_abort = 1'b0;
      sd_ack = 1'b0;
      step();
      checks++;
      if (done !== 1'b1 || rd_valid !== 1'b0) begin
         failures++; $display("FAIL rstack_abort done=%b rd_valid=%b required done=1 rd_valid=0", done, rd_valid);
      end
      step();
      $display("reset with sd_ack high: new sd_rd after ack low, lba=%0d", sd_lba);
   endtask

   initial begin
      reset = 1'b1; img_present = 1'b1; img_readonly = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_track = 7'd0; req_side = 1'b0; req_sector = 8'd0; req_abort = 1'b0; rd_ready = 1'b0;
      wr_data = 8'd0; wr_valid = 1'b0; sd_ack = 1'b0; sd_buff_addr = 9'd0; sd_buff_dout = 8'd0;
      sd_buff_wr = 1'b0;
      test_reset();
      test_read(7'd0, 1'b0, 8'd1, 32'd0, 1'b0);
      test_read(7'd5, 1'b1, 8'd9, 32'd107, 1'b1);
      test_rnf();
`ifdef FDD_SERVER_WRITE_EN
      test_write();
`else
      test_write_disabled();
`endif
      test_abort();
      test_reset_with_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
